control_stage_seq: RTL and testbench

- Stage sequencer directly upstream of the counter-control decoder.
- Walks a layer through its processing stages 0..last_stage and counts steps inside each stage.
- Drives to the decoder: read-side stage index (rd_stage), last-step flag (rd_lstep) and write-side stage index (wr_stage). wr_stage lags the read side by the datapath write latency.
- Pure control; no datapath storage.

---
 rtl/control_stage_seq_if.sv | 34 +++
 rtl/control_stage_seq.sv | 172 +++++++++++++++++
 tb/tb_control_stage_seq.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_stage_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | control_stage_seq_if : control/status bundle of the stage sequencer        |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface control_stage_seq_if #(
  parameter int CNT_W = 8,
  parameter int N_STG = 10
);
  logic                     start;
  logic                     clr;
  logic                     step_en;
  logic [3:0]               last_stage;
  logic [N_STG*CNT_W-1:0]   cfg_len;

  logic [3:0]               rd_stage;
  logic                     rd_lstep;
  logic [3:0]               wr_stage;
  logic                     wr_valid;
  logic [CNT_W-1:0]         step_cnt;
  logic                     busy;
  logic                     done;

  modport master (
    output start, clr, step_en, last_stage, cfg_len,
    input  rd_stage, rd_lstep, wr_stage, wr_valid, step_cnt, busy, done
  );

  modport slave (
    input  start, clr, step_en, last_stage, cfg_len,
    output rd_stage, rd_lstep, wr_stage, wr_valid, step_cnt, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/control_stage_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | control_stage_seq : walks a layer through its stages, counts steps per     |
// | stage and feeds read/write stage indices to the counter-control decoder.   |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module control_stage_seq #(
  parameter int CNT_W  = 8,
  parameter int N_STG  = 10,
  parameter int WR_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  control_stage_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] c_last_max  = 4'(N_STG - 1);
  localparam logic [4:0] c_n_stg     = 5'(N_STG);
  localparam logic [3:0] c_drain_max = 4'(WR_LAT - 1);

  state_t           state_q, state_d;
  logic [3:0]       rd_stage_q, rd_stage_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic [3:0]       last_q, last_d;
  logic [3:0]       drain_q, drain_d;

  logic [CNT_W-1:0] w_len [16];
  logic             w_run;
  logic             w_lstep;

  // Full 16-entry table so any 4-bit stage index is a legal lookup.
  generate
    for (genvar s = 0; s < 16; s++) begin : g_len
      if (s < N_STG) begin : g_used
        assign w_len[s] = bus.cfg_len[s*CNT_W +: CNT_W];
      end else begin : g_unused
        assign w_len[s] = '0;
      end
    end
  endgenerate

  assign w_run   = (state_q == S_RUN);
  assign w_lstep = w_run && (step_cnt_q == w_len[rd_stage_q]);

  always_comb begin
    state_d    = state_q;
    rd_stage_d = rd_stage_q;
    step_cnt_d = step_cnt_q;
    last_d     = last_q;
    drain_d    = drain_q;

    if (bus.clr) begin
      state_d    = S_IDLE;
      rd_stage_d = '0;
      step_cnt_d = '0;
      last_d     = '0;
      drain_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d    = S_RUN;
            rd_stage_d = '0;
            step_cnt_d = '0;
            drain_d    = '0;
            last_d     = ({1'b0, bus.last_stage} >= c_n_stg) ? c_last_max : bus.last_stage;
          end
        end
        S_RUN: begin
          if (bus.step_en) begin
            if (!w_lstep) begin
              step_cnt_d = step_cnt_q + CNT_W'(1);
            end else if (rd_stage_q != last_q) begin
              rd_stage_d = rd_stage_q + 4'd1;
              step_cnt_d = '0;
            end else begin
              state_d    = S_DRAIN;
              step_cnt_d = '0;
              drain_d    = '0;
            end
          end
        end
        S_DRAIN: begin
          if (drain_q == c_drain_max) begin
            state_d = S_DONE;
          end else begin
            drain_d = drain_q + 4'd1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rd_stage_q <= '0;
      step_cnt_q <= '0;
      last_q     <= '0;
      drain_q    <= '0;
    end else begin
      state_q    <= state_d;
      rd_stage_q <= rd_stage_d;
      step_cnt_q <= step_cnt_d;
      last_q     <= last_d;
      drain_q    <= drain_d;
    end
  end

  // Stage fields only load behind a live entry, so the tail keeps the last live stage.
  logic       dl_valid_q [WR_LAT];
  logic [3:0] dl_stage_q [WR_LAT];

  generate
    for (genvar i = 0; i < WR_LAT; i++) begin : g_dl
      if (i == 0) begin : g_head
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            dl_valid_q[i] <= 1'b0;
            dl_stage_q[i] <= '0;
          end else if (bus.clr) begin
            dl_valid_q[i] <= 1'b0;
            dl_stage_q[i] <= '0;
          end else begin
            dl_valid_q[i] <= w_run;
            if (w_run) begin
              dl_stage_q[i] <= rd_stage_q;
            end
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            dl_valid_q[i] <= 1'b0;
            dl_stage_q[i] <= '0;
          end else if (bus.clr) begin
            dl_valid_q[i] <= 1'b0;
            dl_stage_q[i] <= '0;
          end else begin
            dl_valid_q[i] <= dl_valid_q[i-1];
            if (dl_valid_q[i-1]) begin
              dl_stage_q[i] <= dl_stage_q[i-1];
            end
          end
        end
      end
    end
  endgenerate

  assign bus.rd_stage = rd_stage_q;
  assign bus.rd_lstep = w_lstep;
  assign bus.step_cnt = step_cnt_q;
  assign bus.wr_valid = dl_valid_q[WR_LAT-1];
  assign bus.wr_stage = dl_stage_q[WR_LAT-1];
  assign bus.busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done     = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_control_stage_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_control_stage_seq : scoreboard bench for the stage sequencer            |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_control_stage_seq;

  localparam int CNT_W  = 8;
  localparam int N_STG  = 10;
  localparam int WR_LAT = 2;

  typedef struct packed {
    logic [3:0]       rd_stage;
    logic             rd_lstep;
    logic [CNT_W-1:0] step_cnt;
    logic             wr_valid;
    logic [3:0]       wr_stage;
    logic             busy;
    logic             done;
  } exp_t;

  logic clk;
  logic rst_n;

  control_stage_seq_if #(.CNT_W(CNT_W), .N_STG(N_STG)) bus ();

  control_stage_seq #(.CNT_W(CNT_W), .N_STG(N_STG), .WR_LAT(WR_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  string cur_test = "init";

  // Two-cycle history of {run, rd_stage} yields the expected write side.
  logic       h0_run, h1_run;
  logic [3:0] h0_stage, h1_stage, wr_held;

  int t1_st [6] = '{0, 0, 1, 2, 2, 2};
  int t1_cnt[6] = '{0, 1, 0, 0, 1, 2};
  int t1_l  [6] = '{0, 1, 1, 0, 0, 1};
  int st_en [6] = '{1, 0, 0, 1, 1, 1};
  int st_cnt[6] = '{0, 1, 1, 1, 2, 3};
  int ab_st [7] = '{0, 0, 1, 1, 2, 2, 3};
  int ab_cnt[7] = '{0, 1, 0, 1, 0, 1, 0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_begin();
    h0_run = 1'b0; h1_run = 1'b0; h0_stage = '0; h1_stage = '0;
  endtask

  task automatic model_clear();
    model_begin();
    wr_held = '0;
  endtask

  task automatic push_row(input int st, input int l, input int cnt,
                          input bit run, input bit bsy, input bit dn);
    exp_t e;
    e.rd_stage = 4'(st);
    e.rd_lstep = 1'(l);
    e.step_cnt = CNT_W'(cnt);
    e.wr_valid = h1_run;
    if (h1_run) wr_held = h1_stage;
    e.wr_stage = wr_held;
    e.busy     = bsy;
    e.done     = dn;
    h1_run = h0_run; h1_stage = h0_stage;
    h0_run = run;    h0_stage = 4'(st);
    exp_q.push_back(e);
  endtask

  task automatic push_tail(input int st);
    push_row(st, 0, 0, 1'b0, 1'b1, 1'b0);
    push_row(st, 0, 0, 1'b0, 1'b1, 1'b0);
    push_row(st, 0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic push_test1();
    model_begin();
    for (int i = 0; i < 6; i++) push_row(t1_st[i], t1_l[i], t1_cnt[i], 1'b1, 1'b1, 1'b0);
    push_tail(2);
  endtask

  task automatic set_all_lens(input int v);
    for (int s = 0; s < N_STG; s++) bus.cfg_len[s*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  task automatic set_len(input int s, input int v);
    bus.cfg_len[s*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d expected rows never observed, required 0", cur_test, exp_q.size());
      exp_q.delete();
    end
    repeat (3) tick();
  endtask

  task automatic check_zero(input string name);
    exp_t got;
    got.rd_stage = bus.rd_stage; got.rd_lstep = bus.rd_lstep; got.step_cnt = bus.step_cnt;
    got.wr_valid = bus.wr_valid; got.wr_stage = bus.wr_stage;
    got.busy = bus.busy; got.done = bus.done;
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL %s: outputs=%h required 0", name, got);
    end
  endtask

  always @(negedge clk) begin
    exp_t got;
    exp_t e;
    if (rst_n && (bus.busy || bus.done)) begin
      got.rd_stage = bus.rd_stage; got.rd_lstep = bus.rd_lstep; got.step_cnt = bus.step_cnt;
      got.wr_valid = bus.wr_valid; got.wr_stage = bus.wr_stage;
      got.busy = bus.busy; got.done = bus.done;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s unexpected: st=%0d l=%0d cnt=%0d wv=%0d ws=%0d busy=%0d done=%0d, required no output",
                 cur_test, got.rd_stage, got.rd_lstep, got.step_cnt, got.wr_valid, got.wr_stage,
                 got.busy, got.done);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL %s row: got st=%0d l=%0d cnt=%0d wv=%0d ws=%0d busy=%0d done=%0d, required st=%0d l=%0d cnt=%0d wv=%0d ws=%0d busy=%0d done=%0d",
                   cur_test, got.rd_stage, got.rd_lstep, got.step_cnt, got.wr_valid, got.wr_stage,
                   got.busy, got.done, e.rd_stage, e.rd_lstep, e.step_cnt, e.wr_valid, e.wr_stage,
                   e.busy, e.done);
        end
      end
    end
  end

  initial begin
    bus.start = 1'b0; bus.clr = 1'b0; bus.step_en = 1'b0;
    bus.last_stage = '0; bus.cfg_len = '0;
    model_clear();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Basic layer with write lag
    cur_test = "basic";
    set_all_lens(7); set_len(0, 1); set_len(1, 0); set_len(2, 2);
    bus.last_stage = 4'd2; bus.step_en = 1'b1;
    push_test1();
    pulse_start();
    wait_empty();

    // Start pulses while busy must not restart the layer
    cur_test = "start_ignored";
    push_test1();
    pulse_start();
    tick(); tick();
    pulse_start();
    tick(); tick(); tick();
    pulse_start();
    wait_empty();

    // Stall with step_en pattern
    cur_test = "stall";
    set_all_lens(0); set_len(0, 3);
    bus.last_stage = 4'd0;
    model_begin();
    for (int i = 0; i < 6; i++) push_row(0, (st_cnt[i] == 3) ? 1 : 0, st_cnt[i], 1'b1, 1'b1, 1'b0);
    push_tail(0);
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      bus.step_en = 1'(st_en[i]);
      tick();
    end
    bus.step_en = 1'b1;
    wait_empty();

    // All stages one step long, last_stage at the top slot
    cur_test = "boundary9";
    set_all_lens(0);
    bus.last_stage = 4'd9;
    model_begin();
    for (int s = 0; s < 10; s++) push_row(s, 1, 0, 1'b1, 1'b1, 1'b0);
    push_tail(9);
    pulse_start();
    wait_empty();

    // Out-of-range last_stage is clamped to the top slot
    cur_test = "clamp12";
    bus.last_stage = 4'd12;
    model_begin();
    for (int s = 0; s < 10; s++) push_row(s, 1, 0, 1'b1, 1'b1, 1'b0);
    push_tail(9);
    pulse_start();
    wait_empty();

    // clr beats start in the same cycle; also clears held stage/write side
    cur_test = "clr_start";
    bus.start = 1'b1; bus.clr = 1'b1;
    tick();
    bus.start = 1'b0; bus.clr = 1'b0;
    check_zero("clr_beats_start");
    model_clear();
    repeat (3) tick();
    check_zero("clr_start_stays_idle");

    // clr during stage 3
    cur_test = "clr_mid";
    set_all_lens(1);
    bus.last_stage = 4'd5;
    model_begin();
    for (int i = 0; i < 7; i++) push_row(ab_st[i], ab_cnt[i], ab_cnt[i], 1'b1, 1'b1, 1'b0);
    pulse_start();
    for (int i = 1; i < 7; i++) tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check_zero("clr_idle");
    model_clear();
    wait_empty();

    // Asynchronous reset mid-run, then a fresh layer
    cur_test = "async_rst";
    set_all_lens(7); set_len(0, 1); set_len(1, 0); set_len(2, 2);
    bus.last_stage = 4'd2;
    model_begin();
    for (int i = 0; i < 3; i++) push_row(t1_st[i], t1_l[i], t1_cnt[i], 1'b1, 1'b1, 1'b0);
    pulse_start();
    tick(); tick();
    #5 rst_n = 1'b0;
    #1 check_zero("async_reset");
    model_clear();
    @(posedge clk);
    #3 rst_n = 1'b1;
    wait_empty();
    check_zero("no_resume_after_reset");

    cur_test = "after_reset";
    push_test1();
    pulse_start();
    wait_empty();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
